// File: rtl/serial_neuron.sv
// Serial multiply-accumulate neuron: accepts N (data, weight) pairs one per
// beat, adds a bias sampled on the first beat, rounds and saturates the sum
// back to Q(QM.QN), then holds the result until downstream accepts it.
module serial_neuron #(
  parameter int N  = 4,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [QM+QN-1:0]     in_data,
  input  logic signed [WM+WN-1:0]     in_weight,
  input  logic signed [QM+QN-1:0]     bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [QM+QN-1:0]     out_data
);

  localparam int DW = QM + QN;               // data / bias / result width
  localparam int WW = WM + WN;               // weight width
  localparam int PW = DW + WW;               // full product width
  localparam int AW = PW + $clog2(N) + 1;    // accumulator width, overflow-free
  localparam int FW = AW + 2;                // headroom for bias add and rounding
  localparam int CW = $clog2(N + 1);         // beat counter width

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [FW-1:0] HALF     = {{(FW-1){1'b0}}, 1'b1} << (WN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  state_r;
  logic signed [AW-1:0]    acc_r;
  logic        [CW-1:0]    count_r;
  logic signed [DW-1:0]    bias_r;
  logic signed [DW-1:0]    out_data_r;
  logic                    out_valid_r;

  logic                    beat_s;
  logic signed [PW-1:0]    data_ext_s;
  logic signed [PW-1:0]    weight_ext_s;
  logic signed [PW-1:0]    prod_s;
  logic signed [AW-1:0]    acc_base_s;
  logic signed [AW-1:0]    acc_sum_s;
  logic signed [DW-1:0]    bias_sel_s;
  logic signed [FW-1:0]    bias_sh_s;
  logic signed [FW-1:0]    final_s;
  logic signed [FW-1:0]    round_s;
  logic signed [FW-1:0]    scaled_s;
  logic signed [DW-1:0]    sat_s;

  // Clamp a wide scaled value into the signed DW-bit result range.
  function automatic logic signed [DW-1:0] sat_fn(input logic signed [FW-1:0] v);
    logic [FW-DW:0] top;
    top = v[FW-1:DW-1];
    if ((top == {(FW-DW+1){1'b0}}) || (top == {(FW-DW+1){1'b1}})) begin
      sat_fn = v[DW-1:0];
    end else if (v[FW-1]) begin
      sat_fn = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_fn = {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

  // Pairs are accepted whenever out of reset and not holding a result.
  assign in_ready  = nrst & (state_r != S_OUT);
  assign beat_s    = in_valid & in_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Datapath: product, running sum, bias alignment, rounding and saturation.
  always_comb begin
    data_ext_s   = $signed({{(PW-DW){in_data[DW-1]}}, in_data});
    weight_ext_s = $signed({{(PW-WW){in_weight[WW-1]}}, in_weight});
    prod_s       = data_ext_s * weight_ext_s;
    // First beat of a vector starts from zero and uses the live bias input.
    if (state_r == S_IDLE) begin
      acc_base_s = {AW{1'b0}};
      bias_sel_s = bias;
    end else begin
      acc_base_s = acc_r;
      bias_sel_s = bias_r;
    end
    acc_sum_s = acc_base_s + $signed({{(AW-PW){prod_s[PW-1]}}, prod_s});
    bias_sh_s = $signed({{(FW-DW){bias_sel_s[DW-1]}}, bias_sel_s}) <<< WN;
    final_s   = $signed({{(FW-AW){acc_sum_s[AW-1]}}, acc_sum_s}) + bias_sh_s;
    round_s   = final_s + $signed(HALF);
    scaled_s  = round_s >>> WN;
    sat_s     = sat_fn(scaled_s);
  end

  // Control FSM with registered result and valid flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r     <= S_IDLE;
      acc_r       <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      bias_r      <= {DW{1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (beat_s) begin
            acc_r   <= acc_sum_s;
            bias_r  <= bias;
            count_r <= CNT_ONE;
            if (N == 1) begin
              state_r     <= S_OUT;
              out_data_r  <= sat_s;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (beat_s) begin
            acc_r   <= acc_sum_s;
            count_r <= count_r + CNT_ONE;
            if (count_r == LAST_CNT) begin
              state_r     <= S_OUT;
              out_data_r  <= sat_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_neuron.sv
// Scoreboard bench for serial_neuron: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_serial_neuron;

  localparam int N  = 4;
  localparam int QM = 3;
  localparam int QN = 5;
  localparam int WM = 6;
  localparam int WN = 10;
  localparam int DW = QM + QN;
  localparam int WW = WM + WN;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic signed [WW-1:0] in_weight;
  logic signed [DW-1:0] bias;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic signed [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  serial_neuron #(.N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every accepted result must match the oldest expected value.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0d expected no result", out_data);
      end else begin
        check("out_data", int'(out_data), int'(sb_q.pop_front()));
      end
    end
  end

  // Present one pair and wait (bounded) until it is accepted.
  task automatic beat(input int d, input int w);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(d);
    in_weight = WW'(w);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  // Issue one 4-pair vector; bias switches to b1 after the first beat.
  task automatic run_vec(input int d0, input int d1, input int d2, input int d3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int b0, input int b1, input int gapmax, input int expv);
    int dd[4];
    int ww[4];
    dd = '{d0, d1, d2, d3};
    ww = '{w0, w1, w2, w3};
    sb_q.push_back(DW'(expv));
    bias = DW'(b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && gapmax > 0) begin
        repeat ($urandom_range(gapmax, 0)) begin
          @(posedge clk);
          #1;
        end
      end
      beat(dd[i], ww[i]);
      bias = DW'(b1);
    end
    check("latency_out_valid", int'(out_valid), 1);
    check("busy_in_ready", int'(in_ready), 0);
  endtask

  // Wait (bounded) until the monitor has consumed every expected result.
  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    bias      = '0;
    out_ready = 1'b0;
    #2;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // Nominal: 4 x (0.5 * 1.0) + 0.25 = 2.25
    run_vec(16, 16, 16, 16, 1024, 1024, 1024, 1024, 8, 8, 0, 72);
    drain();
    check("nominal_idle_valid", int'(out_valid), 0);
    check("nominal_idle_ready", int'(in_ready), 1);

    // Saturation both ways
    run_vec(-128, -128, -128, -128, 4096, 4096, 4096, 4096, 0, 0, 0, -128);
    drain();
    run_vec(127, 127, 127, 127, 4096, 4096, 4096, 4096, 0, 0, 0, 127);
    drain();

    // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds toward +inf to 0
    run_vec(1, 0, 0, 0, 512, 0, 0, 0, 0, 0, 0, 1);
    drain();
    run_vec(-1, 0, 0, 0, 512, 0, 0, 0, 0, 0, 0, 0);
    drain();

    // Gaps and backpressure, with in_valid junk ignored while holding
    out_ready = 1'b0;
    run_vec(16, 16, 16, 16, 1024, 1024, 1024, 1024, 8, 8, 2, 72);
    in_valid  = 1'b1;
    in_data   = DW'(50);
    in_weight = WW'(1000);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_out_data", int'(out_data), 72);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("release_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("release_out_valid", int'(out_valid), 0);
    check("release_in_ready_next", int'(in_ready), 1);
    drain();

    // Mid-operation reset discards two accepted beats
    bias = DW'(8);
    beat(16, 1024);
    beat(16, 1024);
    nrst = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #1;
    check("midrst_release_ready", int'(in_ready), 1);
    run_vec(16, 16, 16, 16, 1024, 1024, 1024, 1024, 8, 8, 0, 72);
    drain();

    // Bias change after the first beat has no effect
    run_vec(16, 16, 16, 16, 1024, 1024, 1024, 1024, 8, 100, 0, 72);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
